// File: rtl/vga_framebuffer_arbiter_if.sv
// Signal bundle between the frame-buffer arbiter, its three users and the video RAM.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface vga_framebuffer_arbiter_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 3
);
    logic                  iVgaRead;
    logic [ADDR_WIDTH-1:0] iVgaAddress;
    logic [DATA_WIDTH-1:0] oVgaColor;
    logic                  oVgaValid;
    logic                  iWrReq;
    logic [ADDR_WIDTH-1:0] iWrAddress;
    logic [DATA_WIDTH-1:0] iWrData;
    logic                  oWrAck;
    logic                  iClearStart;
    logic [DATA_WIDTH-1:0] iClearColor;
    logic                  oClearBusy;
    logic                  oClearDone;
    logic [ADDR_WIDTH-1:0] oMemAddress;
    logic                  oMemWriteEnable;
    logic [DATA_WIDTH-1:0] oMemData;
    logic [DATA_WIDTH-1:0] iMemData;

    modport slave (
        input  iVgaRead, iVgaAddress, iWrReq, iWrAddress, iWrData,
               iClearStart, iClearColor, iMemData,
        output oVgaColor, oVgaValid, oWrAck, oClearBusy, oClearDone,
               oMemAddress, oMemWriteEnable, oMemData
    );

    modport master (
        output iVgaRead, iVgaAddress, iWrReq, iWrAddress, iWrData,
               iClearStart, iClearColor, iMemData,
        input  oVgaColor, oVgaValid, oWrAck, oClearBusy, oClearDone,
               oMemAddress, oMemWriteEnable, oMemData
    );
endinterface

// File: rtl/vga_framebuffer_arbiter.sv
// Single-port frame-buffer arbiter: VGA read > fill engine > host write, one access per cycle.
// The grant is decided in cycle N and every output is registered, so the access appears in N+1.
module vga_framebuffer_arbiter #(
    parameter int ADDR_WIDTH  = 19,
    parameter int DATA_WIDTH  = 3,
    parameter int DEPTH       = 307200,
    parameter int MEM_LATENCY = 1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    vga_framebuffer_arbiter_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] LP_DEPTH = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_count, w_count_next;
    logic [DATA_WIDTH-1:0] r_fill_color, w_fill_color_next;

    logic                  w_vga_in_range;
    logic                  w_fill_grant;
    logic                  w_fill_last;
    logic                  w_wr_grant;
    logic                  w_wr_in_range;

    logic [MEM_LATENCY:0]  r_vld_pipe;
    logic [MEM_LATENCY:0]  r_oor_pipe;

    logic [DATA_WIDTH-1:0] r_vga_color;
    logic                  r_vga_valid;
    logic                  r_wr_ack;
    logic                  r_clear_busy;
    logic                  r_clear_done;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_we;
    logic [DATA_WIDTH-1:0] r_mem_data;

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch can be inferred.
        w_state_next      = r_state;
        w_count_next      = r_count;
        w_fill_color_next = r_fill_color;
        w_vga_in_range    = (bus.iVgaAddress < LP_DEPTH);
        w_wr_in_range     = (bus.iWrAddress < LP_DEPTH);
        w_fill_grant      = (r_state == CLEAR) && !bus.iVgaRead;
        w_fill_last       = w_fill_grant && (r_count == LP_LAST);
        // The ack-cycle block limits host writes to one every two clocks.
        w_wr_grant        = bus.iWrReq && !bus.iVgaRead && (r_state == IDLE) && !r_wr_ack;

        case (r_state)
            IDLE: begin
                if (bus.iClearStart) begin
                    w_state_next      = CLEAR;
                    w_count_next      = '0;
                    w_fill_color_next = bus.iClearColor;
                end
            end
            CLEAR: begin
                if (w_fill_last) begin
                    w_state_next = IDLE;
                    w_count_next = '0;
                end else if (w_fill_grant) begin
                    w_count_next = r_count + ADDR_WIDTH'(1);
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_fill_color <= '0;
            r_vld_pipe   <= '0;
            r_oor_pipe   <= '0;
            r_vga_color  <= '0;
            r_vga_valid  <= 1'b0;
            r_wr_ack     <= 1'b0;
            r_clear_busy <= 1'b0;
            r_clear_done <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_data   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            r_fill_color <= w_fill_color_next;
            r_wr_ack     <= w_wr_grant;
            r_clear_done <= w_fill_last;
            r_clear_busy <= (w_state_next == CLEAR);
            r_mem_we     <= 1'b0;

            // An out-of-range VGA read still owns the slot but leaves the RAM port untouched.
            if (bus.iVgaRead) begin
                if (w_vga_in_range) begin
                    r_mem_addr <= bus.iVgaAddress;
                end
            end else if (w_fill_grant) begin
                r_mem_addr <= r_count;
                r_mem_data <= r_fill_color;
                r_mem_we   <= 1'b1;
            end else if (w_wr_grant && w_wr_in_range) begin
                r_mem_addr <= bus.iWrAddress;
                r_mem_data <= bus.iWrData;
                r_mem_we   <= 1'b1;
            end

            // Stage k is visible in cycle N+1+k; RAM data is valid alongside the last stage.
            r_vld_pipe  <= {r_vld_pipe[MEM_LATENCY-1:0], bus.iVgaRead};
            r_oor_pipe  <= {r_oor_pipe[MEM_LATENCY-1:0], bus.iVgaRead && !w_vga_in_range};
            r_vga_valid <= r_vld_pipe[MEM_LATENCY];
            if (r_vld_pipe[MEM_LATENCY]) begin
                r_vga_color <= r_oor_pipe[MEM_LATENCY] ? '0 : bus.iMemData;
            end
        end
    end

    assign bus.oVgaColor       = r_vga_color;
    assign bus.oVgaValid       = r_vga_valid;
    assign bus.oWrAck          = r_wr_ack;
    assign bus.oClearBusy      = r_clear_busy;
    assign bus.oClearDone      = r_clear_done;
    assign bus.oMemAddress     = r_mem_addr;
    assign bus.oMemWriteEnable = r_mem_we;
    assign bus.oMemData        = r_mem_data;
endmodule

// File: tb/tb_vga_framebuffer_arbiter.sv
// Bench for vga_framebuffer_arbiter on a reduced 192-pixel frame with a registered RAM model.
// A cycle-level event model predicts every output; directed tests add literal expectations.
module tb_vga_framebuffer_arbiter;
    localparam int AW    = 8;
    localparam int DW    = 3;
    localparam int DEPTH = 192;
    localparam int ML    = 1;
    localparam int MSIZE = 1 << AW;

    logic Clock = 1'b0;
    logic Reset;

    initial forever #5 Clock = ~Clock;

    vga_framebuffer_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    vga_framebuffer_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .MEM_LATENCY(ML)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Registered single-port RAM, one clock read latency, read-before-write.
    logic [DW-1:0] ram [MSIZE];
    initial begin : ram_model
        for (int i = 0; i < MSIZE; i++) ram[i] = DW'(i % 8);
        bus.iMemData = '0;
        forever begin
            @(posedge Clock);
            bus.iMemData <= ram[bus.oMemAddress];
            if (bus.oMemWriteEnable === 1'b1) ram[bus.oMemAddress] <= bus.oMemData;
        end
    end

    // Event model: each cycle's grant schedules what must appear 1 and 3 cycles later.
    typedef struct packed {
        logic          addr_set;
        logic [AW-1:0] addr;
        logic          data_set;
        logic [DW-1:0] data;
        logic          we;
        logic          ack;
        logic          done;
        logic          vld;
        logic          color_set;
        logic [DW-1:0] color;
    } slot_t;

    slot_t         slots [4];
    logic [DW-1:0] ref_mem [MSIZE];
    int ack_cnt = 0, vld_cnt = 0, we_cnt = 0, busy_cnt = 0, done_cnt = 0;
    int done_bad = 0, oor_we = 0, last_done_cyc = 0, last_ack_cyc = 0;

    initial begin : model
        slot_t         cur;
        logic          armed, cur_ack, fill_active, was_active;
        int            fill_pos, n;
        logic [DW-1:0] fill_color, c;
        logic [AW-1:0] hold_addr, exp_addr;
        logic [DW-1:0] hold_data, exp_data, hold_color, exp_color;
        for (int i = 0; i < MSIZE; i++) ref_mem[i] = DW'(i % 8);
        for (int s = 0; s < 4; s++) slots[s] = '0;
        armed = 1'b0; fill_active = 1'b0; fill_pos = 0; fill_color = '0; n = 0;
        hold_addr = '0; hold_data = '0; hold_color = '0;
        forever begin
            @(negedge Clock);
            cur_ack = 1'b0;
            if (armed) begin
                cur = slots[n % 4];
                slots[n % 4] = '0;
                exp_addr  = cur.addr_set  ? cur.addr  : hold_addr;
                exp_data  = cur.data_set  ? cur.data  : hold_data;
                exp_color = cur.color_set ? cur.color : hold_color;
                check("vga_valid",  32'(bus.oVgaValid),       32'(cur.vld));
                check("vga_color",  32'(bus.oVgaColor),       32'(exp_color));
                check("wr_ack",     32'(bus.oWrAck),          32'(cur.ack));
                check("clear_busy", 32'(bus.oClearBusy),      32'(fill_active));
                check("clear_done", 32'(bus.oClearDone),      32'(cur.done));
                check("mem_we",     32'(bus.oMemWriteEnable), 32'(cur.we));
                check("mem_addr",   32'(bus.oMemAddress),     32'(exp_addr));
                check("mem_data",   32'(bus.oMemData),        32'(exp_data));
                hold_addr = exp_addr; hold_data = exp_data; hold_color = exp_color;
                cur_ack = cur.ack;
                if (bus.oWrAck === 1'b1) begin ack_cnt++; last_ack_cyc = n; end
                if (bus.oVgaValid === 1'b1) vld_cnt++;
                if (bus.oMemWriteEnable === 1'b1) we_cnt++;
                if (bus.oClearBusy === 1'b1) busy_cnt++;
                if (bus.oMemWriteEnable === 1'b1 && int'(bus.oMemAddress) >= DEPTH) oor_we++;
                if (bus.oClearDone === 1'b1) begin
                    done_cnt++;
                    last_done_cyc = n;
                    if (!(bus.oMemWriteEnable === 1'b1 && int'(bus.oMemAddress) == DEPTH - 1))
                        done_bad++;
                end
            end
            if (Reset === 1'b0) begin
                for (int s = 0; s < 4; s++) slots[s] = '0;
                slots[(n + 1) % 4].addr_set  = 1'b1;
                slots[(n + 1) % 4].data_set  = 1'b1;
                slots[(n + 1) % 4].color_set = 1'b1;
                fill_active = 1'b0; fill_pos = 0; fill_color = '0;
                armed = 1'b1;
            end else if (armed) begin
                was_active = fill_active;
                if (bus.iVgaRead) begin
                    c = '0;
                    if (int'(bus.iVgaAddress) < DEPTH) begin
                        slots[(n + 1) % 4].addr_set = 1'b1;
                        slots[(n + 1) % 4].addr     = bus.iVgaAddress;
                        c = ref_mem[bus.iVgaAddress];
                    end
                    slots[(n + 3) % 4].vld       = 1'b1;
                    slots[(n + 3) % 4].color_set = 1'b1;
                    slots[(n + 3) % 4].color     = c;
                end else if (was_active) begin
                    slots[(n + 1) % 4].we       = 1'b1;
                    slots[(n + 1) % 4].addr_set = 1'b1;
                    slots[(n + 1) % 4].addr     = AW'(fill_pos);
                    slots[(n + 1) % 4].data_set = 1'b1;
                    slots[(n + 1) % 4].data     = fill_color;
                    ref_mem[fill_pos] = fill_color;
                    if (fill_pos == DEPTH - 1) begin
                        slots[(n + 1) % 4].done = 1'b1;
                        fill_active = 1'b0;
                        fill_pos = 0;
                    end else begin
                        fill_pos++;
                    end
                end else if (bus.iWrReq && !cur_ack) begin
                    slots[(n + 1) % 4].ack = 1'b1;
                    if (int'(bus.iWrAddress) < DEPTH) begin
                        slots[(n + 1) % 4].we       = 1'b1;
                        slots[(n + 1) % 4].addr_set = 1'b1;
                        slots[(n + 1) % 4].addr     = bus.iWrAddress;
                        slots[(n + 1) % 4].data_set = 1'b1;
                        slots[(n + 1) % 4].data     = bus.iWrData;
                        ref_mem[bus.iWrAddress] = bus.iWrData;
                    end
                end
                if (!was_active && bus.iClearStart) begin
                    fill_active = 1'b1;
                    fill_pos    = 0;
                    fill_color  = bus.iClearColor;
                end
            end
            n++;
        end
    end

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive_idle();
        bus.iVgaRead = 1'b0; bus.iVgaAddress = '0;
        bus.iWrReq = 1'b0; bus.iWrAddress = '0; bus.iWrData = '0;
        bus.iClearStart = 1'b0; bus.iClearColor = '0;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic seen = 1'b0;
        bus.iWrReq = 1'b1; bus.iWrAddress = a; bus.iWrData = d;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge Clock);
            if (bus.oWrAck === 1'b1) seen = 1'b1;
            else cyc();
        end
        check("wr_ack_seen", 32'(seen), 32'd1);
        cyc();
        bus.iWrReq = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic run_fill(input logic [DW-1:0] color, input bit poke);
        logic finished = 1'b0;
        bus.iClearStart = 1'b1; bus.iClearColor = color;
        cyc();
        for (int t = 0; t < 1000 && !finished; t++) begin
            bus.iClearStart = poke && (t == 50);
            bus.iClearColor = (poke && t == 50) ? ~color : color;
            @(negedge Clock);
            if (bus.oClearBusy !== 1'b1) finished = 1'b1;
            else cyc();
        end
        check("fill_finished", 32'(finished), 32'd1);
        drive_idle();
        repeat (3) cyc();
    endtask

    function automatic int ram_mismatches(input int lo, input int hi, input logic [DW-1:0] v);
        int bad = 0;
        for (int i = lo; i <= hi; i++) if (ram[i] !== v) bad++;
        return bad;
    endfunction

    initial begin : stim
        int b0, d0, db0, a0, v0, w0, o0;
        logic seen;
        Reset = 1'b0;
        drive_idle();
        for (int i = 0; i < 10; i++) begin
            bus.iVgaRead = 1'($urandom); bus.iVgaAddress = AW'($urandom);
            bus.iWrReq = 1'($urandom); bus.iWrAddress = AW'($urandom); bus.iWrData = DW'($urandom);
            bus.iClearStart = 1'($urandom); bus.iClearColor = DW'($urandom);
            cyc();
        end
        Reset = 1'b1;
        drive_idle();
        @(negedge Clock);
        check("reset_outputs", 32'({bus.oVgaColor, bus.oVgaValid, bus.oWrAck, bus.oClearBusy,
              bus.oClearDone, bus.oMemAddress, bus.oMemWriteEnable, bus.oMemData}), 32'd0);
        cyc(); cyc();

        // First read after reset: RAM[5] holds 3'b101, valid exactly three clocks later.
        bus.iVgaRead = 1'b1; bus.iVgaAddress = AW'(5);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            bus.iVgaRead = 1'b0;
            @(negedge Clock);
            check($sformatf("first_read_valid_c%0d", k), 32'(bus.oVgaValid), (k == 3) ? 32'd1 : 32'd0);
            if (k == 3) check("first_read_color", 32'(bus.oVgaColor), 32'b101);
        end
        cyc();

        // Host writes: one in range, one out of range.
        a0 = ack_cnt; w0 = we_cnt; o0 = oor_we;
        host_write(AW'(100), 3'b110);
        check("wr_ack_pulses", 32'(ack_cnt - a0), 32'd1);
        check("wr_we_pulses", 32'(we_cnt - w0), 32'd1);
        check("wr_ram_100", 32'(ram[100]), 32'b110);
        a0 = ack_cnt; w0 = we_cnt;
        host_write(AW'(DEPTH), 3'b111);
        check("oor_wr_ack_pulses", 32'(ack_cnt - a0), 32'd1);
        check("oor_wr_we_pulses", 32'(we_cnt - w0), 32'd0);
        check("oor_we_any", 32'(oor_we - o0), 32'd0);

        // Eight back-to-back reads starve a pending host write.
        v0 = vld_cnt; a0 = ack_cnt;
        bus.iWrReq = 1'b1; bus.iWrAddress = AW'(101); bus.iWrData = 3'b010;
        for (int i = 0; i < 8; i++) begin
            bus.iVgaRead = 1'b1; bus.iVgaAddress = AW'(10 + i);
            @(negedge Clock);
            check("no_ack_in_burst", 32'(bus.oWrAck), 32'd0);
            cyc();
        end
        bus.iVgaRead = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 2 && !seen; k++) begin
            @(negedge Clock);
            if (bus.oWrAck === 1'b1) seen = 1'b1;
            else cyc();
        end
        check("ack_after_burst", 32'(seen), 32'd1);
        cyc();
        drive_idle();
        repeat (5) cyc();
        check("burst_valid_pulses", 32'(vld_cnt - v0), 32'd8);
        check("burst_ack_pulses", 32'(ack_cnt - a0), 32'd1);
        check("burst_ram_101", 32'(ram[101]), 32'b010);

        // Plain fill; a second start with another colour mid-fill must be ignored.
        b0 = busy_cnt; d0 = done_cnt; db0 = done_bad;
        run_fill(3'b011, 1'b1);
        check("fill_busy_cycles", 32'(busy_cnt - b0), 32'(DEPTH));
        check("fill_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("fill_done_on_last", 32'(done_bad - db0), 32'd0);
        check("fill_ram_011", 32'(ram_mismatches(0, DEPTH - 1, 3'b011)), 32'd0);

        // Fill interleaved with a read every fourth cycle and a stalled host write.
        b0 = busy_cnt; d0 = done_cnt;
        bus.iClearStart = 1'b1; bus.iClearColor = 3'b100;
        cyc();
        bus.iClearStart = 1'b0;
        bus.iWrReq = 1'b1; bus.iWrAddress = AW'(50); bus.iWrData = 3'b001;
        seen = 1'b0;
        for (int t = 1; t <= 1000 && !seen; t++) begin
            bus.iVgaRead = ((t - 1) % 4 == 0);
            bus.iVgaAddress = AW'(t * 7);
            @(negedge Clock);
            if (bus.oWrAck === 1'b1) seen = 1'b1;
            else cyc();
        end
        check("interleave_ack_seen", 32'(seen), 32'd1);
        cyc();
        drive_idle();
        repeat (5) cyc();
        check("interleave_busy_cycles", 32'(busy_cnt - b0), 32'd256);
        check("interleave_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("interleave_ack_after_done", 32'(last_ack_cyc > last_done_cyc), 32'd1);
        check("interleave_ram_50", 32'(ram[50]), 32'b001);
        check("interleave_ram_fill", 32'(ram_mismatches(51, DEPTH - 1, 3'b100)), 32'd0);

        // Reset with the fill counter at 100.
        d0 = done_cnt;
        bus.iClearStart = 1'b1; bus.iClearColor = 3'b010;
        cyc();
        bus.iClearStart = 1'b0;
        repeat (100) cyc();
        Reset = 1'b0;
        cyc(); cyc();
        Reset = 1'b1;
        @(negedge Clock);
        check("abort_busy", 32'(bus.oClearBusy), 32'd0);
        repeat (3) cyc();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_ram_low", 32'(ram_mismatches(0, 99, 3'b010)), 32'd0);
        check("abort_ram_high", 32'(ram_mismatches(100, DEPTH - 1, 3'b100)), 32'd0);

        b0 = busy_cnt;
        run_fill(3'b111, 1'b0);
        check("refill_busy_cycles", 32'(busy_cnt - b0), 32'(DEPTH));
        check("refill_ram_111", 32'(ram_mismatches(0, DEPTH - 1, 3'b111)), 32'd0);

        begin
            int bad = 0;
            for (int i = 0; i < MSIZE; i++) if (ram[i] !== ref_mem[i]) bad++;
            check("ram_vs_model", 32'(bad), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: reached time %0t, required finish before it", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
